// File: rtl/seq_div_8bit.sv
// seq_div_8bit: multi-cycle restoring divider, one quotient bit per clock.
// Latency: done pulses WIDTH+1 cycles after the accepting edge, or 1 cycle when the divisor is 0.
// Backpressure: start is ignored while busy=1; results are held until the next accepted start.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               command strobe, sampled only when busy=0
//   dividend, divisor   operands, captured on the accepting edge
//   busy, done          in-flight indicator / one-cycle result-valid pulse
//   quotient, remainder registered results, held until the next accepted start
//   div_by_zero         set with done when the captured divisor was 0
//
// Build option: define DIV_SIGNED_EN for two's-complement (DIV) semantics;
// leave it undefined for unsigned (DIVU) semantics with no sign logic.
module seq_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvsr_mag;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start in the DONE cycle is accepted directly, so there is no idle gap.
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted partial remainder is below 2*divisor, so
  // the WIDTH+1-bit difference never overflows and its MSB is the sign.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_dvsr};
    if (!w_trial[WIDTH]) begin
      w_rem_nxt = w_trial[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning and result sign fix-up
  // ---------------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end

  // The magnitude of the most-negative value is exact as an unsigned number,
  // so MIN / -1 falls out as quotient = MIN with no special case.
  assign w_dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvsr_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign w_quo_fix  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
`else
  assign w_dvd_mag  = dividend;
  assign w_dvsr_mag = divisor;
  assign w_quo_fix  = w_quo_nxt;
  assign w_rem_fix  = w_rem_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Datapath and result registers (results load only on entry to DONE)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvsr      <= w_dvsr_mag;
      r_rem       <= '0;
      r_quo       <= w_dvd_mag;
      div_by_zero <= 1'b0;
      if (divisor == '0) begin
        // Divide by zero skips RUN and reports the raw dividend.
        r_cnt       <= '0;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r_cnt <= CW'(WIDTH);
      end
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        quotient  <= w_quo_fix;
        remainder <= w_rem_fix;
      end
    end
  end

endmodule
